// File: rtl/cover_toggle_sched.sv
// Serializes first-hit toggle coverage into a one-index-per-cycle valid/ready stream,
// with a seen bitmap, distinct-hit counter and a drain-then-clear re-arm sequence.
module cover_toggle_sched #(
    parameter int unsigned WIDTH       = 130,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int unsigned COVER_TOTAL = 8940
) (
    input  logic                         gbl_clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         clear_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_index,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         clear_ack,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    state_t           state;
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] hits;
    logic [WIDTH-1:0] low_mask;
    logic [PW-1:0]    low_pos;
    logic [CW:0]      hit_cnt;
    logic [CW:0]      cnt_sum;
    logic [CW-1:0]    cnt_next;
    logic             free;
    logic             pend_any;

    always_comb begin
        hits     = (state == RUN) ? (valid & ~seen) : '0;
        free     = !out_valid || out_ready;
        pend_any = |pend;
        // Isolate the lowest pending bit; its position is the next report.
        low_mask = pend & (~pend + WIDTH'(1));
        low_pos  = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pend[i]) low_pos = PW'(i);
        end
        hit_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            hit_cnt = hit_cnt + (CW+1)'(hits[i]);
        end
        cnt_sum  = {1'b0, covered_count} + hit_cnt;
        cnt_next = (cnt_sum > (CW+1)'(WIDTH)) ? CW'(WIDTH) : cnt_sum[CW-1:0];
        busy     = (state != RUN) || pend_any || out_valid;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            state         <= RUN;
            seen          <= '0;
            pend          <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
            clear_ack     <= 1'b0;
        end else begin
            clear_ack <= 1'b0;
            if (free) begin
                if (pend_any) begin
                    out_valid <= 1'b1;
                    out_index <= COVER_INDEX + 64'(low_pos);
                end else begin
                    out_valid <= 1'b0;
                end
            end
            // Load uses pre-edge pend, so bits captured this edge wait one cycle.
            pend          <= (free ? (pend & ~low_mask) : pend) | hits;
            seen          <= seen | hits;
            covered_count <= cnt_next;
            case (state)
                RUN:   if (clear_req) state <= DRAIN;
                DRAIN: begin
                    if (!pend_any && free) begin
                        state         <= CLEAR;
                        clear_ack     <= 1'b1;
                        seen          <= '0;
                        covered_count <= '0;
                    end
                end
                CLEAR:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (reset) begin
            assert (cnt_sum <= (CW+1)'(WIDTH));
            assert (!out_valid || (out_index < 64'(COVER_TOTAL)));
        end
    end

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed and randomized checks of cover_toggle_sched against a cycle-level reference model.
module tb_cover_toggle_sched;

    localparam int W  = 130;
    localparam int CW = $clog2(W + 1);

    logic          gbl_clk = 1'b0;
    logic          reset;
    logic [W-1:0]  valid;
    logic          clear_req;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [CW-1:0] covered_count;
    logic          clear_ack;
    logic          busy;

    cover_toggle_sched #(
        .WIDTH(W),
        .COVER_INDEX(64'd0),
        .COVER_TOTAL(8940)
    ) dut (
        .gbl_clk(gbl_clk),
        .reset(reset),
        .valid(valid),
        .clear_req(clear_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .covered_count(covered_count),
        .clear_ack(clear_ack),
        .busy(busy)
    );

    always #5 gbl_clk = ~gbl_clk;

    int n_vec = 0;
    int n_err = 0;
    int got_q[$];
    int exp_q[$];
    int ack_seen;

    // Reference model: "is this point known", "is it still owed a report",
    // what the consumer currently sees, and which phase of the re-arm we are in.
    bit     m_seen[W];
    bit     m_owed[W];
    bit     m_ov;
    longint m_idx;
    int     m_cnt;
    bit     m_ack;
    bit     m_draining;
    bit     m_clearing;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  lo;
        bit  taken;
        bit  go_clear;
        if (!reset) begin
            foreach (m_seen[i]) begin m_seen[i] = 0; m_owed[i] = 0; end
            m_ov = 0; m_idx = 0; m_cnt = 0; m_ack = 0;
            m_draining = 0; m_clearing = 0;
            return;
        end
        taken = !m_ov || out_ready;
        lo = -1;
        for (int i = 0; i < W; i++) if (m_owed[i] && lo < 0) lo = i;
        go_clear = m_draining && lo < 0 && taken;
        if (taken) begin
            if (lo >= 0) begin m_ov = 1; m_idx = lo; m_owed[lo] = 0; end
            else m_ov = 0;
        end
        m_ack = 0;
        if (!m_draining && !m_clearing) begin
            for (int i = 0; i < W; i++) begin
                if (valid[i] && !m_seen[i]) begin
                    m_seen[i] = 1; m_owed[i] = 1; m_cnt++;
                end
            end
            if (clear_req) m_draining = 1;
        end else if (m_clearing) begin
            m_clearing = 0;
        end else if (go_clear) begin
            m_draining = 0; m_clearing = 1; m_ack = 1; m_cnt = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end
    endtask

    function automatic bit model_busy();
        bit any = 0;
        foreach (m_owed[i]) any |= m_owed[i];
        return m_draining || m_clearing || any || m_ov;
    endfunction

    task automatic step();
        if (reset && out_valid && out_ready) got_q.push_back(int'(out_index));
        if (clear_ack) ack_seen++;
        model_edge();
        @(posedge gbl_clk);
        #1;
        chk("out_valid", longint'(out_valid), longint'(m_ov));
        if (m_ov) chk("out_index", longint'(out_index), m_idx);
        chk("covered_count", longint'(covered_count), longint'(m_cnt));
        chk("clear_ack", longint'(clear_ack), longint'(m_ack));
        chk("busy", longint'(busy), longint'(model_busy()));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_reports(input string tag);
        chk({tag, "_len"}, longint'(got_q.size()), longint'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk({tag, "_item"}, longint'(got_q[k]), longint'(exp_q[k]));
        got_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; valid = '0; clear_req = 1'b0; out_ready = 1'b1;
        steps(2);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_index", longint'(out_index), 0);
        chk("rst_count", longint'(covered_count), 0);
        chk("rst_busy", longint'(busy), 0);
        reset = 1'b1;
        got_q.delete();
        ack_seen = 0;
    endtask

    initial begin
        valid = '0; clear_req = 1'b0; out_ready = 1'b1; reset = 1'b0;
        ack_seen = 0;

        // Single hit: report visible two cycles after the hit cycle, for one cycle.
        do_reset();
        valid[5] = 1'b1; step();
        valid = '0;
        chk("single_early", longint'(out_valid), 0);
        step();
        chk("single_valid", longint'(out_valid), 1);
        chk("single_index", longint'(out_index), 5);
        step();
        chk("single_drop", longint'(out_valid), 0);
        chk("single_count", longint'(covered_count), 1);
        got_q.delete();

        // Multi-bit hit reported in ascending order.
        do_reset();
        valid[129] = 1'b1; valid[0] = 1'b1; valid[64] = 1'b1; step();
        valid = '0; steps(6);
        exp_q = {0, 64, 129}; chk_reports("order");
        chk("order_count", longint'(covered_count), 3);

        // Repeat hits are suppressed.
        do_reset();
        valid[7] = 1'b1; steps(10);
        valid = '0; steps(3);
        valid[7] = 1'b1; step();
        valid = '0; steps(4);
        exp_q = {7}; chk_reports("suppress");
        chk("suppress_count", longint'(covered_count), 1);

        // Backpressure holds the head; a lower late arrival overtakes 9.
        do_reset();
        out_ready = 1'b0;
        valid[3] = 1'b1; valid[9] = 1'b1; step();
        valid = '0; step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_hold_index", longint'(out_index), 3);
        end
        valid[1] = 1'b1; step();
        valid = '0; out_ready = 1'b1; steps(6);
        exp_q = {3, 1, 9}; chk_reports("bp_seq");

        // Drain then clear; hits during drain are dropped, re-hit after clear reports again.
        do_reset();
        valid[2] = 1'b1; valid[4] = 1'b1; valid[6] = 1'b1; valid[8] = 1'b1; step();
        valid = '0; clear_req = 1'b1; step();
        clear_req = 1'b0; valid[20] = 1'b1; steps(3);
        valid = '0; steps(8);
        exp_q = {2, 4, 6, 8}; chk_reports("clear_drain");
        chk("clear_ack_pulses", longint'(ack_seen), 1);
        chk("clear_count", longint'(covered_count), 0);
        valid[3] = 1'b1; step();
        valid = '0; steps(4);
        exp_q = {3}; chk_reports("rearm");
        chk("rearm_count", longint'(covered_count), 1);

        // Reset in the middle of a drain discards everything owed.
        do_reset();
        out_ready = 1'b0;
        valid[10] = 1'b1; valid[11] = 1'b1; valid[12] = 1'b1; step();
        valid = '0; clear_req = 1'b1; step();
        clear_req = 1'b0; steps(2);
        reset = 1'b0; step();
        reset = 1'b1; out_ready = 1'b1;
        chk("middrain_valid", longint'(out_valid), 0);
        chk("middrain_count", longint'(covered_count), 0);
        chk("middrain_busy", longint'(busy), 0);
        got_q.delete();
        steps(6);
        chk("middrain_stale", longint'(got_q.size()), 0);

        // Randomized traffic, including full-width bursts, clears and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) valid = '1;
            else for (int i = 0; i < W; i++) valid[i] = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear_req = ($urandom_range(0, 119) == 0);
            reset     = ($urandom_range(0, 699) != 0);
            step();
        end
        reset = 1'b1; valid = '0; clear_req = 1'b0; out_ready = 1'b1;
        steps(W + 10);
        chk("final_idle", longint'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
